// File: rtl/regfile_sequencer_pkg.sv
// Shared constants for the register-file sequencer: widths, opcodes and FSM encoding.
package regfile_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_LDI = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB1  = 3'd3,
    ST_WB2  = 3'd4
  } state_e;
endpackage

// File: rtl/regfile_sequencer_alu8.sv
// Combinational 8-bit ALU: result plus zero and carry/borrow flags.
module alu8
  import regfile_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c
);
  logic [DATA_W:0] wide;

  always_comb begin
    wide   = '0;
    result = '0;
    c      = 1'b0;
    case (op)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_W-1:0];
        c      = wide[DATA_W];
      end
      // The 9th bit of the widened difference is set exactly when a < b.
      OP_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DATA_W-1:0];
        c      = wide[DATA_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MOV:  result = a;
      OP_LDI:  result = imm;
      default: result = '0;
    endcase
    z = (result == '0);
  end
endmodule

// File: rtl/regfile_sequencer.sv
// Single-issue read / execute / write-back sequencer for the 8x8 register file.
module regfile_sequencer
  import regfile_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs0,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [DATA_W-1:0] in_imm,
  output logic [ADDR_W-1:0] rf_read_addr0,
  output logic [ADDR_W-1:0] rf_read_addr1,
  input  logic [DATA_W-1:0] rf_read_data0,
  input  logic [DATA_W-1:0] rf_read_data1,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_load_enable,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              flag_c
);
  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] rs0_q, rs0_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              z_q, z_d;
  logic              c_q, c_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] alu_result;
  logic              alu_z;
  logic              alu_c;

  alu8 u_alu (
    .op     (op_q),
    .a      (rf_read_data0),
    .b      (rf_read_data1),
    .imm    (imm_q),
    .result (alu_result),
    .z      (alu_z),
    .c      (alu_c)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rs0_d    = rs0_q;
    rs1_d    = rs1_q;
    imm_d    = imm_q;
    result_d = result_q;
    z_d      = z_q;
    c_d      = c_q;
    done_d   = 1'b0;
    case (state_q)
      // Source addresses are captured at accept so they are already on the read ports during READ.
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          rd_d    = in_rd;
          rs0_d   = in_rs0;
          rs1_d   = in_rs1;
          imm_d   = in_imm;
          state_d = ST_READ;
        end
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: begin
        if (op_q == OP_NOP) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          result_d = alu_result;
          z_d      = alu_z;
          c_d      = alu_c;
          state_d  = ST_WB1;
        end
      end
      ST_WB1:  state_d = ST_WB2;
      ST_WB2: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NOP;
      rd_q     <= '0;
      rs0_q    <= '0;
      rs1_q    <= '0;
      imm_q    <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs0_q    <= rs0_d;
      rs1_q    <= rs1_d;
      imm_q    <= imm_d;
      result_q <= result_d;
      z_q      <= z_d;
      c_q      <= c_d;
      done_q   <= done_d;
    end
  end

  // The file captures write data one edge after enable, so address and data stay stable across both WB states.
  assign in_ready       = (state_q == ST_IDLE);
  assign rf_read_addr0  = rs0_q;
  assign rf_read_addr1  = rs1_q;
  assign rf_load_enable = (state_q == ST_WB1) || (state_q == ST_WB2);
  assign rf_write_addr  = rd_q;
  assign rf_write_data  = result_q;
  assign done           = done_q;
  assign result         = result_q;
  assign flag_z         = z_q;
  assign flag_c         = c_q;
endmodule
